// File: rtl/sseg_scan_mux.sv
// sseg_scan_mux: four-digit seven-segment scan multiplexer with frame-aligned double buffering.
// Define SSEG_SCAN_DEADTIME_EN to blank the first DEAD_CYCLES clocks of every digit slot.
module sseg_scan_mux #(
    parameter int REFRESH_BITS = 18,
    parameter int DEAD_CYCLES  = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    input  logic       load,
    output logic [3:0] an,
    output logic [7:0] sseg,
    output logic       frame_tick
);
`ifdef SSEG_SCAN_DEADTIME_EN
    localparam bit DEAD_EN = 1'b1;
`else
    localparam bit DEAD_EN = 1'b0;
`endif
    localparam logic [REFRESH_BITS-3:0] DEAD = (REFRESH_BITS-2)'(DEAD_CYCLES);

    logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
    logic [3:0][7:0]         pend_q, pend_d, shadow_q, shadow_d, in_w;
    logic                    pend_flag_q, pend_flag_d;
    logic [3:0]              an_q, an_d;
    logic [7:0]              sseg_q, sseg_d;
    logic                    tick_q;
    logic                    wrap, blank;
    logic [1:0]              sel;

    assign in_w  = {in3, in2, in1, in0};
    assign wrap  = &cnt_q;
    assign sel   = cnt_q[REFRESH_BITS-1 -: 2];
    assign blank = DEAD_EN && (cnt_q[REFRESH_BITS-3:0] < DEAD);

    // A load on the wrap edge bypasses pending so the new frame shows it immediately.
    always_comb begin
        cnt_d       = cnt_q + 1'b1;
        pend_d      = load ? in_w : pend_q;
        pend_flag_d = wrap ? 1'b0 : (load | pend_flag_q);
        shadow_d    = !wrap ? shadow_q : load ? in_w : pend_flag_q ? pend_q : shadow_q;
        an_d        = blank ? 4'hF : ~(4'b0001 << sel);
        sseg_d      = blank ? 8'hFF : shadow_q[sel];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            pend_q      <= {4{8'hFF}};
            shadow_q    <= {4{8'hFF}};
            pend_flag_q <= 1'b0;
            an_q        <= 4'hF;
            sseg_q      <= 8'hFF;
            tick_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            shadow_q    <= shadow_d;
            pend_flag_q <= pend_flag_d;
            an_q        <= an_d;
            sseg_q      <= sseg_d;
            tick_q      <= wrap;
        end
    end

    assign an         = an_q;
    assign sseg       = sseg_q;
    assign frame_tick = tick_q;
endmodule

// File: tb/tb_sseg_scan_mux.sv
// tb_sseg_scan_mux: randomized scoreboard bench for sseg_scan_mux (REFRESH_BITS=6, DEAD_CYCLES=4).
module tb_sseg_scan_mux;
    localparam int RB = 6, DC = 4, FRAME = 64, SLOT = 16;
`ifdef SSEG_SCAN_DEADTIME_EN
    localparam bit DT = 1'b1;
`else
    localparam bit DT = 1'b0;
`endif
    typedef struct packed {
        logic [3:0] an;
        logic [7:0] sseg;
        logic       tick;
    } exp_t;

    logic       clk = 1'b0, reset_n = 1'b1, load = 1'b0;
    logic [7:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic [3:0] an;
    logic [7:0] sseg;
    logic       frame_tick;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         errors = 0, checks = 0;
    int         qm = 0;
    logic [7:0] disp[4], nxt[4];
    bit         pend = 0, in_rst = 1, rel = 0;

    sseg_scan_mux #(.REFRESH_BITS(RB), .DEAD_CYCLES(DC)) dut (
        .clk(clk), .reset_n(reset_n), .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .load(load), .an(an), .sseg(sseg), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every registered output is compared against the oldest prediction.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("an", {28'd0, an}, {28'd0, mon_e.an});
            chk("sseg", {24'd0, sseg}, {24'd0, mon_e.sseg});
            chk("frame_tick", {31'd0, frame_tick}, {31'd0, mon_e.tick});
        end
    end

    // Model: a displayed frame buffer plus one pending frame, swapped only at the frame boundary.
    task automatic cycle(input bit ld, input logic [31:0] v);
        exp_t e;
        int   slot;
        bit   blank;
        @(negedge clk);
        if (rel) begin
            reset_n = 1'b1;
            in_rst  = 0;
            rel     = 0;
        end
        load = ld;
        {in3, in2, in1, in0} = v;
        @(posedge clk);
        if (in_rst) begin
            exp_q.push_back('{4'hF, 8'hFF, 1'b0});
        end else begin
            slot   = qm / SLOT;
            blank  = DT && ((qm % SLOT) < DC);
            e.an   = blank ? 4'hF : 4'(~(4'b0001 << slot));
            e.sseg = blank ? 8'hFF : disp[slot];
            e.tick = (qm == FRAME - 1);
            exp_q.push_back(e);
            if (qm == FRAME - 1) begin
                if (ld) for (int i = 0; i < 4; i++) disp[i] = v[8*i +: 8];
                else if (pend) disp = nxt;
                pend = 0;
            end else if (ld) begin
                for (int i = 0; i < 4; i++) nxt[i] = v[8*i +: 8];
                pend = 1;
            end
            qm = (qm + 1) % FRAME;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        load = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async_an", {28'd0, an}, 32'hF);
        chk("async_sseg", {24'd0, sseg}, 32'hFF);
        chk("async_tick", {31'd0, frame_tick}, 32'd0);
        in_rst = 1;
        qm     = 0;
        pend   = 0;
        for (int i = 0; i < 4; i++) disp[i] = 8'hFF;
        repeat (3) cycle(0, 0);
        rel = 1;
    endtask

    task automatic run_to(input int target);
        for (int k = 0; k < 2 * FRAME && qm != target; k++) cycle(0, 0);
    endtask

    initial begin
        do_reset();
        repeat (128) cycle(0, 0);
        run_to(10);
        cycle(1, 32'hB0A4F9C0);
        repeat (70) cycle(0, 0);
        run_to(20);
        cycle(1, 32'h43424140);
        run_to(30);
        cycle(1, 32'h7C7B7A79);
        repeat (80) cycle(0, 0);
        run_to(63);
        cycle(1, 32'h19302412);
        repeat (130) cycle(0, 0);
        run_to(40);
        cycle(1, $urandom);
        run_to(50);
        do_reset();
        repeat (128) cycle(0, 0);
        repeat (600) cycle($urandom_range(0, 7) == 0, $urandom);
        repeat (200) cycle(1, $urandom);
        repeat (70) cycle(0, 0);
        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sseg_scan_mux.md
SSEG_SCAN_MUX -- requirements
Module: sseg_scan_mux

Interface
REQ-001 Parameter REFRESH_BITS, default 18, refresh counter width; frame = 2^REFRESH_BITS clocks, digit slot = 2^(REFRESH_BITS-2) clocks.
REQ-002 Parameter DEAD_CYCLES, default 64, blanking clocks at start of each slot; SHALL be < 2^(REFRESH_BITS-2).
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in0..in3  input  8 each  active-low segment patterns per digit (bit7 = dp, bits6:0 = g..a); in0 = rightmost digit.
REQ-006 load  input  1  single-cycle strobe; captures in0..in3 for display from the next frame boundary.
REQ-007 an  output  4  active-low digit enables; an[i] drives digit i.
REQ-008 sseg  output  8  active-low segment/dp bus to the display.
REQ-009 frame_tick  output  1  one-clock pulse per frame wrap.

Function
REQ-010 Free-running counter q (REFRESH_BITS wide) SHALL increment every clock, wrapping 2^REFRESH_BITS-1 -> 0.
REQ-011 Slot select sel = q[REFRESH_BITS-1:REFRESH_BITS-2]; sel=0..3 selects digit 0..3.
REQ-012 an and sseg SHALL be registered: one-clock latency from q. an is one-hot-low at bit sel. sseg = shadow[sel].
REQ-013 Pending registers: on load=1, in0..in3 SHALL be stored into pending[0..3] and pend_flag set. Repeated loads before a wrap: the last load wins.
REQ-014 Transfer edge = the edge where q goes max -> 0. On it: if load=1, shadow <= in0..in3 directly and pend_flag cleared. Else if pend_flag=1, shadow <= pending and pend_flag cleared. Else shadow unchanged.
REQ-015 Shadow SHALL never change except on a transfer edge. No partially updated frame SHALL be displayed.
REQ-016 frame_tick SHALL be 1 for exactly the one clock following the transfer edge, i.e. while q=0 is registered. Otherwise 0.
REQ-017 load held high continuously: capture every cycle, and transfer each frame of the inputs present on the transfer edge.
REQ-018 Any X-free input SHALL pass through unmodified. No decoding SHALL be done; segment encoding is the upstream decoder's job.

Reset
REQ-019 reset_n=0 SHALL, asynchronously: q=0, shadow all 8'hFF, pending all 8'hFF, pend_flag=0, an=4'b1111, sseg=8'hFF, frame_tick=0.
REQ-020 Deassertion is synchronized externally. The first clock after release SHALL register slot 0, and q counts from 0.
REQ-021 Reset mid-frame or with pend_flag=1 SHALL discard pending data. The display SHALL be blank until the first load and its transfer edge.

Configuration
REQ-022 Macro SSEG_SCAN_DEADTIME_EN. When defined: while q[REFRESH_BITS-3:0] < DEAD_CYCLES, an SHALL be 4'b1111 and sseg 8'hFF (ghosting suppression). Otherwise per REQ-012.
REQ-023 Without SSEG_SCAN_DEADTIME_EN: no blanking, DEAD_CYCLES ignored, and the selected digit SHALL be enabled for the full slot.

Verification (REFRESH_BITS=6, DEAD_CYCLES=4; slot = 16 clocks, frame = 64 clocks)
REQ-024 Reset -> an=1111, sseg=FF, frame_tick=0. Release, no load, for 128 clocks -> sseg stays FF; an cycles 1110, 1101, 1011, 0111 every 16 clocks; frame_tick pulses at clocks 64 and 128.
REQ-025 load at clock 10 with in0..3=C0,F9,A4,B0 -> sseg stays FF until the frame wrap. In frame 2: slot0 sseg=C0/an=1110, slot1 F9/1101, slot2 A4/1011, slot3 B0/0111.
REQ-026 load at clock 20 (values 40..43), then load at clock 30 (values 79..7C) -> the next frame shows 79..7C only.
REQ-027 load asserted on the q=63 cycle with 12,24,30,19 -> the frame starting at q=0 shows 12,24,30,19 immediately, and pend_flag=0 afterwards.
REQ-028 load at clock 40, reset_n pulsed low at clock 50 -> outputs blank at once. After release, the display stays blank through 2 frames.
REQ-029 With SSEG_SCAN_DEADTIME_EN: the first 4 clocks of every slot give an=1111/sseg=FF and the remaining 12 give the normal digit. Without the macro, no 1111 appears after reset.
